cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
- Two-master pipelined Wishbone arbiter that shares the single slave port of the write-back cache between the instruction-fetch and data masters.
- Grants the slave for a whole bus cycle (cyc), round-robin on contention.
- Throttles each owner to MAXOUT unacknowledged strobes.
- Aborts a stuck cycle with err after TIMEOUT ack-less cycles.

Parameters:
AWIDTH, 32, address width in bytes, passed straight through
DWIDTH, 32, data width; select width is DWIDTH/8
MAXOUT, 4, max accepted-but-unacked strobes per grant (1..15)
TIMEOUT, 255, ack-less cycles with outstanding>0 before abort; 0 disables watchdog

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
mN_cyc, mN_stb, mN_we (N=0,1)  in  1 each  master cycle/strobe/write
mN_adr  in  AWIDTH  master address
mN_sel  in  DWIDTH/8  byte selects
mN_dat_m  in  DWIDTH  master write data
mN_dat_s  out  DWIDTH  read data to master
mN_ack, mN_stall, mN_err  out  1 each  slave-side handshake to master
s_cyc, s_stb, s_we  out  1 each  to cache inbus
s_adr  out  AWIDTH;  s_sel  out  DWIDTH/8;  s_dat_m  out  DWIDTH
s_dat_s  in  DWIDTH;  s_ack, s_stall  in  1 each  from cache
grant  out  2  one-hot current owner, 00 when idle

Behaviour:
- Reset is rst_i, asynchronous, active-high; clock is clk_i.
- Reset state:
  - state=A_IDLE; last=1, so m0 wins the first tie.
  - outstanding=0, wdog=0.
- Reset output values:
  - s_cyc/s_stb/s_we=0; s_adr/s_sel/s_dat_m=0.
  - mN_ack=0, mN_err=0, mN_stall=1, grant=00.
- States are A_IDLE, A_M0, A_M1, A_ABORT. Grant is registered: a request sampled at edge k is driven to the slave from cycle k+1.
- A_IDLE:
  - Slave outputs are 0; both stalls are 1.
  - m0_cyc&m1_cyc -> grant the master != last.
  - Only one cyc asserted -> grant that master.
  - Neither -> stay.
- A_Mx (owner x), combinational pass-through:
  - s_cyc/s_we/s_adr/s_sel/s_dat_m = mx_*.
  - s_stb = mx_stb & ~full.
  - mx_stall = s_stall | full.
  - mx_ack = s_ack.
  - Non-owner: stall=1, ack=0, err=0.
  - mN_dat_s = s_dat_s for both masters at all times.
- Outstanding counter, with full = (outstanding==MAXOUT):
  - +1 on s_stb&~s_stall.
  - -1 on s_ack.
  - Both in the same cycle -> unchanged.
  - s_ack while outstanding==0 -> counter stays 0, ack still forwarded.
- Release:
  - Owner cyc low at an edge -> A_IDLE, last=x, outstanding=0, wdog=0.
  - This gives one mandatory dead cycle (s_cyc=0) between grants, even if the other master is waiting.
- Watchdog:
  - wdog increments each cycle with outstanding>0 & ~s_ack; it clears on s_ack or outstanding==0.
  - On wdog==TIMEOUT-1 with no ack: mx_err=1 for exactly one cycle, next state A_ABORT.
  - TIMEOUT=0 disables the watchdog: counter held at 0, no err.
- A_ABORT:
  - s_cyc=s_stb=0; owner stall=1, ack suppressed; grant still shows owner.
  - Stay until owner cyc=0, then A_IDLE with last=owner, counters cleared.
- Reset asserted mid-cycle: immediate return to reset values. No acks are replayed; in-flight slave acks after reset are ignored.
- grant = {state==A_M1|abort-owner1, state==A_M0|abort-owner0}.

Test Plan:
- Single m0 read (cyc,stb at cycle 0, adr=0x100):
  - grant=01 at cycle 1; s_stb=1 with s_adr=0x100 at cycle 1.
  - s_ack with s_dat_s=0xDEADBEEF -> m0_ack=1, m0_dat_s=0xDEADBEEF same cycle.
  - m0 drops cyc -> grant=00 next cycle.
- Simultaneous requests from reset:
  - m0 granted first.
  - After m0 releases: one idle cycle, then grant=10.
  - Next tie after m1 releases -> m0.
- MAXOUT=4, s_ack held 0, m0 strobing continuously:
  - Exactly 4 s_stb accepted; then m0_stall=1, s_stb=0.
  - One s_ack -> exactly one more strobe accepted.
- Simultaneous s_ack and accepted strobe at outstanding=3 -> outstanding remains 3, no stall.
- TIMEOUT=8, one accepted strobe, no ack:
  - m0_err pulses 1 cycle at the 8th ack-less cycle; s_cyc=0 next cycle.
  - Stays in abort until m0_cyc=0; m1 then granted after one idle cycle.
- rst_i pulsed while grant=10 with outstanding=2:
  - Outputs return to reset values asynchronously.
  - After release, m0 wins the next tie.

Source files
------------

// File: rtl/cache_arbiter_if.sv
// Pipelined Wishbone bus bundle shared by the arbiter's two master-side ports and its cache-side port.
// The slave modport is what the arbiter presents to a master; the master modport is what it drives into the cache.
interface cache_arbiter_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [AWIDTH-1:0]     adr;
    logic [DWIDTH/8-1:0]   sel;
    logic [DWIDTH-1:0]     dat_m;
    logic [DWIDTH-1:0]     dat_s;
    logic                  ack;
    logic                  stall;
    logic                  err;

    modport master (
        output cyc, stb, we, adr, sel, dat_m,
        input  dat_s, ack, stall
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_m,
        output dat_s, ack, stall, err
    );
endinterface

// File: rtl/cache_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the write-back cache slave port,
// with per-grant strobe throttling and an ack watchdog that aborts stuck bus cycles.
module cache_arbiter #(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int MAXOUT  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    cache_arbiter_if.slave        m0,
    cache_arbiter_if.slave        m1,
    cache_arbiter_if.master       s,
    output logic [1:0]            grant
);

    localparam int             WW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam bit             WD_EN   = (TIMEOUT > 0);
    localparam logic [WW-1:0]  WD_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [3:0]     MAXCNT  = 4'(MAXOUT);

    typedef enum logic [1:0] {
        A_IDLE,
        A_M0,
        A_M1,
        A_ABORT
    } state_t;

    state_t               state, state_nxt;
    logic                 owner, owner_nxt;
    logic                 last, last_nxt;
    logic [3:0]           outstanding;
    logic [WW-1:0]        wdog;

    logic                 own_cyc, own_stb, own_we;
    logic [AWIDTH-1:0]    own_adr;
    logic [DWIDTH/8-1:0]  own_sel;
    logic [DWIDTH-1:0]    own_dat;
    logic                 owned, full, accept, timeout;

    // The owner register stays valid through A_ABORT, so one mux serves both owner states and abort.
    always_comb begin
        own_cyc = owner ? m1.cyc   : m0.cyc;
        own_stb = owner ? m1.stb   : m0.stb;
        own_we  = owner ? m1.we    : m0.we;
        own_adr = owner ? m1.adr   : m0.adr;
        own_sel = owner ? m1.sel   : m0.sel;
        own_dat = owner ? m1.dat_m : m0.dat_m;
    end

    assign owned   = (state == A_M0) || (state == A_M1);
    assign full    = (outstanding == MAXCNT);
    assign accept  = owned && own_stb && !full && !s.stall;
    assign timeout = WD_EN && owned && (outstanding != '0) && !s.ack && (wdog == WD_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= A_IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        case (state)
            A_IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    owner_nxt = ~last;
                end else if (m0.cyc) begin
                    owner_nxt = 1'b0;
                end else if (m1.cyc) begin
                    owner_nxt = 1'b1;
                end
                if (m0.cyc || m1.cyc) begin
                    state_nxt = owner_nxt ? A_M1 : A_M0;
                end
            end
            A_M0, A_M1: begin
                if (!own_cyc) begin
                    state_nxt = A_IDLE;
                    last_nxt  = owner;
                end else if (timeout) begin
                    state_nxt = A_ABORT;
                end
            end
            A_ABORT: begin
                if (!own_cyc) begin
                    state_nxt = A_IDLE;
                    last_nxt  = owner;
                end
            end
            default: state_nxt = A_IDLE;
        endcase
    end

    // Counters only live while a grant persists; any state change wipes them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding <= '0;
            wdog        <= '0;
        end else if (!owned || (state_nxt != state)) begin
            outstanding <= '0;
            wdog        <= '0;
        end else begin
            case ({accept, s.ack})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   if (outstanding != '0) outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
            if (!WD_EN || (outstanding == '0) || s.ack) begin
                wdog <= '0;
            end else begin
                wdog <= wdog + 1'b1;
            end
        end
    end

    always_comb begin
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        s.adr    = '0;
        s.sel    = '0;
        s.dat_m  = '0;
        m0.stall = 1'b1;
        m1.stall = 1'b1;
        m0.ack   = 1'b0;
        m1.ack   = 1'b0;
        m0.err   = 1'b0;
        m1.err   = 1'b0;
        m0.dat_s = s.dat_s;
        m1.dat_s = s.dat_s;
        grant    = 2'b00;
        case (state)
            A_M0, A_M1: begin
                s.cyc   = own_cyc;
                s.stb   = own_stb && !full;
                s.we    = own_we;
                s.adr   = own_adr;
                s.sel   = own_sel;
                s.dat_m = own_dat;
                if (owner == 1'b0) begin
                    m0.stall = s.stall || full;
                    m0.ack   = s.ack;
                    m0.err   = timeout;
                end else begin
                    m1.stall = s.stall || full;
                    m1.ack   = s.ack;
                    m1.err   = timeout;
                end
                grant = owner ? 2'b10 : 2'b01;
            end
            A_ABORT: grant = owner ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against an ownership/pending-count model of the arbiter.
module tb_cache_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int MAXOUT  = 4;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];
    logic [31:0] m_adr [2];
    logic [3:0]  m_sel [2];
    logic [31:0] m_dat [2];
    logic        s_stall, s_ack;
    logic [31:0] s_dat;
    logic [1:0]  grant;

    cache_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) m0_if ();
    cache_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) m1_if ();
    cache_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) s_if ();

    assign m0_if.cyc   = m_cyc[0];
    assign m0_if.stb   = m_stb[0];
    assign m0_if.we    = m_we[0];
    assign m0_if.adr   = m_adr[0];
    assign m0_if.sel   = m_sel[0];
    assign m0_if.dat_m = m_dat[0];
    assign m1_if.cyc   = m_cyc[1];
    assign m1_if.stb   = m_stb[1];
    assign m1_if.we    = m_we[1];
    assign m1_if.adr   = m_adr[1];
    assign m1_if.sel   = m_sel[1];
    assign m1_if.dat_m = m_dat[1];
    assign s_if.stall  = s_stall;
    assign s_if.ack    = s_ack;
    assign s_if.dat_s  = s_dat;
    assign s_if.err    = 1'b0;

    cache_arbiter #(
        .AWIDTH (AW),
        .DWIDTH (DW),
        .MAXOUT (MAXOUT),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if),
        .grant (grant)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    // Model: who owns the bus, whether that grant was aborted, pending strobes and ack-less run length.
    int md_owner, md_last, md_pend, md_quiet;
    bit md_abort;

    function automatic bit md_err();
        return (TIMEOUT > 0) && (md_owner >= 0) && !md_abort && (md_pend > 0)
               && !s_ack && (md_quiet == TIMEOUT - 1);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            md_owner <= -1;
            md_abort <= 1'b0;
            md_last  <= 1;
            md_pend  <= 0;
            md_quiet <= 0;
        end else if (md_owner < 0) begin
            if (m_cyc[0] && m_cyc[1]) md_owner <= 1 - md_last;
            else if (m_cyc[0])        md_owner <= 0;
            else if (m_cyc[1])        md_owner <= 1;
        end else if (!m_cyc[md_owner]) begin
            md_last  <= md_owner;
            md_owner <= -1;
            md_abort <= 1'b0;
            md_pend  <= 0;
            md_quiet <= 0;
        end else if (md_abort) begin
            md_pend <= 0;
        end else if (md_err()) begin
            md_abort <= 1'b1;
            md_pend  <= 0;
            md_quiet <= 0;
        end else begin
            if (m_stb[md_owner] && md_pend < MAXOUT && !s_stall && !s_ack) md_pend <= md_pend + 1;
            else if (!(m_stb[md_owner] && md_pend < MAXOUT && !s_stall) && s_ack && md_pend > 0)
                md_pend <= md_pend - 1;
            md_quiet <= (md_pend > 0 && !s_ack) ? md_quiet + 1 : 0;
        end
    end

    bit          cmp_en = 1'b0;
    logic [1:0]  e_grant, e_stall, e_ack, e_err;
    logic        e_cyc, e_stb, e_we;
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;

    always @(negedge clk) begin
        if (cmp_en) begin
            e_grant = 2'b00; e_stall = 2'b11; e_ack = 2'b00; e_err = 2'b00;
            e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0; e_sel = '0;
            if (md_owner >= 0) begin
                e_grant = (md_owner == 1) ? 2'b10 : 2'b01;
                if (!md_abort) begin
                    e_cyc = m_cyc[md_owner];
                    e_stb = m_stb[md_owner] && (md_pend < MAXOUT);
                    e_we  = m_we[md_owner];
                    e_adr = m_adr[md_owner];
                    e_sel = m_sel[md_owner];
                    e_dat = m_dat[md_owner];
                    e_stall[md_owner] = s_stall || (md_pend == MAXOUT);
                    e_ack[md_owner]   = s_ack;
                    e_err[md_owner]   = md_err();
                end
            end
            chk("cmp_grant",  64'(grant),         64'(e_grant));
            chk("cmp_s_cyc",  64'(s_if.cyc),      64'(e_cyc));
            chk("cmp_s_stb",  64'(s_if.stb),      64'(e_stb));
            chk("cmp_s_we",   64'(s_if.we),       64'(e_we));
            chk("cmp_s_adr",  64'(s_if.adr),      64'(e_adr));
            chk("cmp_s_sel",  64'(s_if.sel),      64'(e_sel));
            chk("cmp_s_datm", 64'(s_if.dat_m),    64'(e_dat));
            chk("cmp_stall",  64'({m1_if.stall, m0_if.stall}), 64'(e_stall));
            chk("cmp_ack",    64'({m1_if.ack, m0_if.ack}),     64'(e_ack));
            chk("cmp_err",    64'({m1_if.err, m0_if.err}),     64'(e_err));
            chk("cmp_dat_s",  64'({m1_if.dat_s, m0_if.dat_s}), {s_dat, s_dat});
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
            m_adr[i] = '0;   m_sel[i] = '0;   m_dat[i] = '0;
        end
        s_stall = 1'b0; s_ack = 1'b0; s_dat = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    int cnt, errc;

    initial begin
        idle_inputs();
        rst = 1'b1;
        cmp_en = 1'b1;
        sample();
        chk("rst_grant",    64'(grant),       64'd0);
        chk("rst_m0_stall", 64'(m0_if.stall), 64'd1);
        chk("rst_s_cyc",    64'(s_if.cyc),    64'd0);
        do_reset();

        // single m0 read
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h100; m_sel[0] = 4'hF;
        next_cycle(); sample();
        chk("rd_grant", 64'(grant), 64'h1);
        chk("rd_s_stb", 64'(s_if.stb), 64'h1);
        chk("rd_s_adr", 64'(s_if.adr), 64'h100);
        next_cycle();
        m_stb[0] = 1'b0; s_ack = 1'b1; s_dat = 32'hDEADBEEF;
        sample();
        chk("rd_m0_ack", 64'(m0_if.ack), 64'h1);
        chk("rd_m0_dat", 64'(m0_if.dat_s), 64'hDEADBEEF);
        next_cycle();
        s_ack = 1'b0; m_cyc[0] = 1'b0;
        next_cycle(); sample();
        chk("rd_release", 64'(grant), 64'h0);

        // tie from reset, alternation, dead cycle
        do_reset();
        m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
        next_cycle(); sample();
        chk("tie_first", 64'(grant), 64'h1);
        next_cycle(); m_cyc[0] = 1'b0;
        next_cycle(); sample();
        chk("tie_dead", 64'(grant), 64'h0);
        next_cycle(); sample();
        chk("tie_second", 64'(grant), 64'h2);
        m_cyc[1] = 1'b0;
        next_cycle(); sample();
        chk("tie_dead2", 64'(grant), 64'h0);
        m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
        next_cycle(); sample();
        chk("tie_third", 64'(grant), 64'h1);

        // throttling at MAXOUT with no acks
        do_reset();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            next_cycle(); sample();
            if (s_if.stb && !s_stall) cnt++;
        end
        chk("thr_accepted", 64'(cnt), 64'd4);
        chk("thr_stall", 64'(m0_if.stall), 64'd1);
        chk("thr_s_stb", 64'(s_if.stb), 64'd0);
        cnt = 0;
        next_cycle(); s_ack = 1'b1; sample();
        if (s_if.stb && !s_stall) cnt++;
        next_cycle(); s_ack = 1'b0; sample();
        if (s_if.stb && !s_stall) cnt++;
        next_cycle(); sample();
        if (s_if.stb && !s_stall) cnt++;
        chk("thr_one_more", 64'(cnt), 64'd1);
        chk("thr_stall2", 64'(m0_if.stall), 64'd1);

        // ack and accepted strobe together at outstanding 3
        do_reset();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        for (int k = 1; k <= 3; k++) next_cycle();
        next_cycle(); s_ack = 1'b1; sample();
        chk("sim_stall_c4", 64'(m0_if.stall), 64'd0);
        chk("sim_stb_c4", 64'(s_if.stb), 64'd1);
        next_cycle(); s_ack = 1'b0; sample();
        chk("sim_stall_c5", 64'(m0_if.stall), 64'd0);
        next_cycle(); sample();
        chk("sim_stall_c6", 64'(m0_if.stall), 64'd1);

        // watchdog abort, then m1 after one dead cycle
        do_reset();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1;
        next_cycle(); sample();
        chk("wd_grant", 64'(grant), 64'h1);
        next_cycle(); m_stb[0] = 1'b0; sample();
        errc = -1;
        for (int k = 3; k <= 20; k++) begin
            next_cycle(); sample();
            if (m0_if.err) begin
                errc = k;
                break;
            end
        end
        chk("wd_err_cycle", 64'(errc), 64'd9);
        next_cycle(); sample();
        chk("wd_err_pulse", 64'(m0_if.err), 64'd0);
        chk("wd_s_cyc", 64'(s_if.cyc), 64'd0);
        chk("wd_abort_grant", 64'(grant), 64'h1);
        next_cycle(); m_cyc[0] = 1'b0; sample();
        chk("wd_abort_hold", 64'(grant), 64'h1);
        next_cycle(); sample();
        chk("wd_idle", 64'(grant), 64'h0);
        next_cycle(); sample();
        chk("wd_m1", 64'(grant), 64'h2);

        // asynchronous reset mid-grant
        do_reset();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        next_cycle(); next_cycle(); next_cycle();
        m_stb[1] = 1'b0;
        sample();
        chk("ar_grant_pre", 64'(grant), 64'h2);
        #2 rst = 1'b1;
        #1;
        chk("ar_grant", 64'(grant), 64'h0);
        chk("ar_s_cyc", 64'(s_if.cyc), 64'h0);
        chk("ar_m1_stall", 64'(m1_if.stall), 64'h1);
        m_cyc[0] = 1'b1; m_cyc[1] = 1'b1; s_ack = 1'b1;
        next_cycle();
        rst = 1'b0; s_ack = 1'b0;
        next_cycle(); sample();
        chk("ar_tie", 64'(grant), 64'h1);

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 399) == 0) rst = 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (m_cyc[i]) begin
                    if ($urandom_range(0, 11) == 0) m_cyc[i] = 1'b0;
                end else if ($urandom_range(0, 5) == 0) begin
                    m_cyc[i] = 1'b1;
                end
                m_stb[i] = m_cyc[i] && ($urandom_range(0, 2) != 0);
                m_we[i]  = 1'($urandom);
                m_adr[i] = $urandom;
                m_sel[i] = 4'($urandom);
                m_dat[i] = $urandom;
            end
            s_stall = ($urandom_range(0, 3) == 0);
            s_ack   = ($urandom_range(0, 9) < 3);
            s_dat   = $urandom;
        end
        sample();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
